led_sense_seq: RTL
==================

Name: led_sense_seq

Overview:
Parametrised multi-channel LED-drive / sense sequencer. It is the digital successor to the single-channel VCR/latch/timing analog chain. For each enabled channel in turn it:
- turns that channel's LED on,
- waits a programmable settle time,
- majority-votes the synchronised comparator output over a fixed sample window,
- latches a per-channel result.

It supports one-shot and continuous scan modes, and sits between the tile's digital I/O and the analog comparator/LED drivers.

Parameters:
- NUM_CH, 4, number of LED/sense channels (2..8)
- CNT_W, 8, width of the settle and gap counters
- SAMPLES, 4, comparator samples per channel (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a scan; level-sampled in IDLE only
- cont  in  1  continuous mode; rescan after a gap
- ch_mask  in  NUM_CH  channel enables; captured at scan start
- settle_cyc  in  CNT_W  LED settle time in cycles; 0 is treated as 1
- gap_cyc  in  CNT_W  idle cycles between continuous scans
- comp_in  in  1  asynchronous comparator output from analog
- led_en  out  NUM_CH  one-hot LED drive, registered
- result  out  NUM_CH  latched per-channel decisions
- result_vld  out  1  one-cycle pulse at end of each scan
- busy  out  1  high in any state other than IDLE
- cur_ch  out  clog2(NUM_CH)  channel being serviced

Behaviour:
- Reset: while rst is high, all outputs are 0, the FSM is in IDLE, the 2-flop comp_in synchroniser is 0, and the captured mask is 0. led_en drops asynchronously, including mid-scan.
- comp_in passes through a 2-flop synchroniser. Only the synchronised value (comp_s) is used.
- FSM states: IDLE, SETTLE, SAMPLE, DECIDE, DONE, GAP.
- IDLE:
  - On start=1 with |ch_mask: capture the mask, set cur_ch to the lowest enabled index, go to SETTLE.
  - start with ch_mask=0 is ignored.
- SETTLE: led_en[cur_ch]=1. Hold for max(settle_cyc,1) cycles, then go to SAMPLE.
- SAMPLE:
  - led_en stays on.
  - Each of SAMPLES cycles adds comp_s to a ones counter.
  - After SAMPLES cycles, go to DECIDE.
- DECIDE:
  - led_en=0.
  - result[cur_ch] <= (ones*2 > SAMPLES), a strict majority; a tie gives 0.
  - If a higher enabled channel exists, set cur_ch to the next enabled index and go to SETTLE. Otherwise go to DONE.
- DONE:
  - result_vld=1 for exactly one cycle.
  - cont=1: go to GAP, or to SETTLE at the lowest enabled channel if gap_cyc=0.
  - cont=0: go to IDLE.
- GAP:
  - Count gap_cyc cycles, then recapture ch_mask.
  - If the new mask is nonzero, go to SETTLE; if zero, go to IDLE.
  - cont=0 during GAP returns to IDLE on the next cycle.
- Channel time: max(settle_cyc,1) + SAMPLES + 1 cycles. led_en is high for max(settle_cyc,1) + SAMPLES cycles.
- Disabled channels are never driven and their result bits hold their previous value.
- start while busy is ignored. settle_cyc and gap_cyc are sampled on entry to SETTLE and GAP respectively. At most one led_en bit is ever high.
- Scan order is ascending channel index.

Optional Feature:
- Macro: LED_SENSE_IRQ_EN.
- When defined, the block adds:
  - input irq_clr;
  - output irq, a sticky flag set in DECIDE when a channel's new result differs from its previous value.
- irq_clr clears irq. If set and clear occur in the same cycle, set wins.
- irq resets to 0.
- When the macro is not defined, neither port exists and there is no added logic.

Test Plan:
- One-shot, single channel:
  - Stimulus: NUM_CH=4, SAMPLES=4, ch_mask=0001, settle_cyc=3, comp_in=1 (stable), start pulse at cycle 0.
  - Response: led_en=0001 during cycles 1-7, DECIDE at cycle 8, result=0001 and result_vld=1 at cycle 9, then busy=0.
- Majority vote:
  - comp_s pattern 1,1,0,0 in the sample window -> result bit 0.
  - Pattern 1,1,1,0 -> result bit 1.
  - Pattern 0,0,0,1 -> result bit 0.
- Masked scan:
  - Stimulus: ch_mask=1010, result preloaded to 0101 by a previous scan, comp_in=1.
  - Response: led_en sequence 0010 then 1000; 0001 and 0100 never seen; final result=1111.
- Continuous mode:
  - Stimulus: cont=1, gap_cyc=5, ch_mask=0001, settle_cyc=2.
  - Response: result_vld pulses exactly 14 cycles apart.
  - Drop cont during GAP -> IDLE within 1 cycle, no further result_vld.
- Reset and edge cases:
  - rst asserted during SAMPLE -> led_en=0 and result=0 immediately, busy=0.
  - start with ch_mask=0 -> stays IDLE.
  - settle_cyc=0 -> same timing as settle_cyc=1.
- IRQ feature (LED_SENSE_IRQ_EN defined):
  - Result changes 0->1 -> irq=1.
  - irq_clr pulse -> irq=0.
  - Rescan with the same result -> irq stays 0.
  - irq_clr in the same cycle as a change -> irq=1.

Source files
------------

// File: rtl/led_sense_seq.sv
// Multi-channel LED drive / comparator sense sequencer with majority voting.
// Optional change-detect interrupt enabled by defining LED_SENSE_IRQ_EN.
module led_sense_seq #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int SAMPLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cont,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [CNT_W-1:0]          settle_cyc,
    input  logic [CNT_W-1:0]          gap_cyc,
    input  logic                      comp_in,
    output logic [NUM_CH-1:0]         led_en,
    output logic [NUM_CH-1:0]         result,
    output logic                      result_vld,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] cur_ch
`ifdef LED_SENSE_IRQ_EN
    ,
    input  logic                      irq_clr,
    output logic                      irq
`endif
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int SW   = $clog2(SAMPLES + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE, GAP} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] led_en_q, led_en_d;
    logic [NUM_CH-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     samp_q, samp_d;
    logic [SW-1:0]     ones_q, ones_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic              sync1_q, sync1_d;
    logic              comp_s_q, comp_s_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic              decision;
    logic [NUM_CH-1:0] higher;
    logic [CNT_W-1:0]  settle_load;
`ifdef LED_SENSE_IRQ_EN
    logic              irq_q, irq_d;
`endif

    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest = i[CH_W-1:0];
        end
    endfunction

    assign settle_load = (settle_cyc == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : settle_cyc;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        samp_d   = samp_q;
        ones_d   = ones_q;
        cur_d    = cur_q;
        sync1_d  = comp_in;
        comp_s_d = sync1_q;
        decision = ((32'(ones_q) * 2) > SAMPLES);
`ifdef LED_SENSE_IRQ_EN
        irq_d    = irq_q & ~irq_clr;
`endif
        // Enabled channels strictly above the one just serviced
        higher = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            higher[i] = mask_q[i] && (i > int'(cur_q));
        end

        case (state_q)
            IDLE: begin
                if (start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    cur_d   = lowest(ch_mask);
                    cnt_d   = settle_load;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    samp_d  = '0;
                    ones_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                ones_d = ones_q + {{(SW-1){1'b0}}, comp_s_q};
                samp_d = samp_q + 1'b1;
                if (samp_q == SW'(SAMPLES - 1)) state_d = DECIDE;
            end
            DECIDE: begin
                result_d[cur_q] = decision;
`ifdef LED_SENSE_IRQ_EN
                if (decision != result_q[cur_q]) irq_d = 1'b1;
`endif
                if (|higher) begin
                    cur_d   = lowest(higher);
                    cnt_d   = settle_load;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!cont) begin
                    state_d = IDLE;
                end else if (gap_cyc == '0) begin
                    cur_d   = lowest(mask_q);
                    cnt_d   = settle_load;
                    state_d = SETTLE;
                end else begin
                    cnt_d   = gap_cyc;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!cont) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // Gap expired: pick up whatever mask is presented now
                    mask_d = ch_mask;
                    if (|ch_mask) begin
                        cur_d   = lowest(ch_mask);
                        cnt_d   = settle_load;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        vld_d    = (state_d == DONE);
        led_en_d = '0;
        if (state_d == SETTLE || state_d == SAMPLE) led_en_d[cur_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            led_en_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            samp_q   <= '0;
            ones_q   <= '0;
            cur_q    <= '0;
            sync1_q  <= 1'b0;
            comp_s_q <= 1'b0;
            busy_q   <= 1'b0;
            vld_q    <= 1'b0;
`ifdef LED_SENSE_IRQ_EN
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            led_en_q <= led_en_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            samp_q   <= samp_d;
            ones_q   <= ones_d;
            cur_q    <= cur_d;
            sync1_q  <= sync1_d;
            comp_s_q <= comp_s_d;
            busy_q   <= busy_d;
            vld_q    <= vld_d;
`ifdef LED_SENSE_IRQ_EN
            irq_q    <= irq_d;
`endif
        end
    end

    assign led_en     = led_en_q;
    assign result     = result_q;
    assign result_vld = vld_q;
    assign busy       = busy_q;
    assign cur_ch     = cur_q;
`ifdef LED_SENSE_IRQ_EN
    assign irq        = irq_q;
`endif

endmodule
